// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, defaults and the write-back entry type for the register file write-port arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  localparam int unsigned QDEPTH_DEFAULT  = 2;
  localparam int unsigned MAX_OUT_DEFAULT = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  // One buffered mul/div result waiting for the write port.
  typedef struct packed {
    reg_addr_t addr;
    xlen_t     data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_result_fifo.sv
// Small FIFO holding mul/div results that lost the write port to the pipeline.
module regfile_wb_arbiter_wb_result_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned QDEPTH = QDEPTH_DEFAULT,
  localparam int unsigned PtrW  = $clog2(QDEPTH),
  localparam int unsigned CntW  = $clog2(QDEPTH + 1)
) (
  input  logic      CLK,
  input  logic      RESET,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  wb_entry_t        mem_q [QDEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CntW'(QDEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Pointer and occupancy next state; pointers wrap naturally since QDEPTH is a power of two.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control state; reset discards every queued entry.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful between push and pop, so no reset.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port owner: pipeline writeback has absolute priority, mul/div results
// are written from a small FIFO or bypassed straight through, and a per-register pending
// scoreboard lets the hazard unit stall readers of in-flight mul/div destinations.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned QDEPTH  = QDEPTH_DEFAULT,
  parameter int unsigned MAX_OUT = MAX_OUT_DEFAULT,
  localparam int unsigned OutW   = $clog2(MAX_OUT + 1)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  PIPE_WRITE,
  input  logic [REG_ADDR_W-1:0] PIPE_ADDR,
  input  logic [XLEN-1:0]       PIPE_DATA,
  input  logic                  MD_ISSUE,
  input  logic [REG_ADDR_W-1:0] MD_ISSUE_ADDR,
  output logic                  MD_ISSUE_READY,
  input  logic                  MD_VALID,
  input  logic [REG_ADDR_W-1:0] MD_ADDR,
  input  logic [XLEN-1:0]       MD_DATA,
  output logic                  MD_READY,
  input  logic [REG_ADDR_W-1:0] RD1_ADDR,
  input  logic [REG_ADDR_W-1:0] RD2_ADDR,
  output logic                  RD1_BUSY,
  output logic                  RD2_BUSY,
  output logic                  RF_WRITE,
  output logic [REG_ADDR_W-1:0] RF_ADDR,
  output logic [XLEN-1:0]       RF_DATA,
  output logic [NUM_REGS-1:0]   PENDING,
  output logic                  ERR
);

  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic [OutW-1:0]       out_q, out_d;
  logic                  err_q, err_d;

  logic                  pipe_act, md_ready, md_hs, md_keep, bypass;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic                  issue_ready, issue_set, md_wr, wr_clr;
  logic                  rf_write;
  logic [REG_ADDR_W-1:0] rf_addr;
  logic [XLEN-1:0]       rf_data;
  wb_entry_t             md_entry, fifo_head;

  assign md_entry = '{addr: MD_ADDR, data: MD_DATA};

  // A pop in the same cycle does not free a slot for the incoming result.
  assign md_ready = !RESET && !fifo_full;

  assign issue_ready = !RESET && (out_q < OutW'(MAX_OUT)) &&
                       !((MD_ISSUE_ADDR != REG_X0) && pending_q[MD_ISSUE_ADDR]);

  regfile_wb_arbiter_wb_result_fifo #(
    .QDEPTH(QDEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (fifo_push),
    .push_entry(md_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Write-port priority: pipeline, then oldest queued result, then direct bypass.
  always_comb begin
    pipe_act  = PIPE_WRITE && (PIPE_ADDR != REG_X0);
    md_hs     = MD_VALID && md_ready;
    md_keep   = md_hs && (MD_ADDR != REG_X0);
    fifo_pop  = !pipe_act && !fifo_empty;
    bypass    = !pipe_act && fifo_empty && md_keep;
    fifo_push = md_keep && !bypass;
    rf_write  = pipe_act || fifo_pop || bypass;
    rf_addr   = PIPE_ADDR;
    rf_data   = PIPE_DATA;
    if (fifo_pop) begin
      rf_addr = fifo_head.addr;
      rf_data = fifo_head.data;
    end else if (bypass) begin
      rf_addr = MD_ADDR;
      rf_data = MD_DATA;
    end
  end

  // Scoreboard next state; a same-register issue overrides the clear from its own write.
  always_comb begin
    md_wr     = fifo_pop || bypass;
    wr_clr    = md_wr && pending_q[rf_addr];
    issue_set = MD_ISSUE && issue_ready && (MD_ISSUE_ADDR != REG_X0);
    pending_d = pending_q;
    if (md_wr) begin
      pending_d[rf_addr] = 1'b0;
    end
    if (issue_set) begin
      pending_d[MD_ISSUE_ADDR] = 1'b1;
    end
    // Only results that retire a pending op decrement, so stray results cannot underflow.
    out_d = out_q;
    if (issue_set && !wr_clr) begin
      out_d = out_q + 1'b1;
    end else if (wr_clr && !issue_set) begin
      out_d = out_q - 1'b1;
    end
  end

  // Sticky protocol error detection.
  always_comb begin
    err_d = err_q;
    if (pipe_act && pending_q[PIPE_ADDR]) begin
      err_d = 1'b1;
    end
    if (md_keep && !pending_q[MD_ADDR]) begin
      err_d = 1'b1;
    end
    if (MD_ISSUE && !issue_ready) begin
      err_d = 1'b1;
    end
  end

  // Scoreboard, outstanding count and error flag registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pending_q <= '0;
      out_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      out_q     <= out_d;
      err_q     <= err_d;
    end
  end

  assign RF_WRITE       = !RESET && rf_write;
  assign RF_ADDR        = rf_addr;
  assign RF_DATA        = rf_data;
  assign MD_READY       = md_ready;
  assign MD_ISSUE_READY = issue_ready;
  assign RD1_BUSY       = !RESET && (RD1_ADDR != REG_X0) && pending_q[RD1_ADDR];
  assign RD2_BUSY       = !RESET && (RD2_ADDR != REG_X0) && pending_q[RD2_ADDR];
  assign PENDING        = pending_q;
  assign ERR            = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: stimulus evaluates a queue/array reference model and pushes the expected
// per-cycle outputs; a negedge monitor pops and compares them against the DUT.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int QD = 2;
  localparam int MO = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        PIPE_WRITE, MD_ISSUE, MD_VALID;
  logic [4:0]  PIPE_ADDR, MD_ISSUE_ADDR, MD_ADDR, RD1_ADDR, RD2_ADDR;
  logic [31:0] PIPE_DATA, MD_DATA;
  logic        MD_ISSUE_READY, MD_READY, RD1_BUSY, RD2_BUSY, RF_WRITE, ERR;
  logic [4:0]  RF_ADDR;
  logic [31:0] RF_DATA, PENDING;

  regfile_wb_arbiter #(
    .QDEPTH (QD),
    .MAX_OUT(MO)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .PIPE_WRITE    (PIPE_WRITE),
    .PIPE_ADDR     (PIPE_ADDR),
    .PIPE_DATA     (PIPE_DATA),
    .MD_ISSUE      (MD_ISSUE),
    .MD_ISSUE_ADDR (MD_ISSUE_ADDR),
    .MD_ISSUE_READY(MD_ISSUE_READY),
    .MD_VALID      (MD_VALID),
    .MD_ADDR       (MD_ADDR),
    .MD_DATA       (MD_DATA),
    .MD_READY      (MD_READY),
    .RD1_ADDR      (RD1_ADDR),
    .RD2_ADDR      (RD2_ADDR),
    .RD1_BUSY      (RD1_BUSY),
    .RD2_BUSY      (RD2_BUSY),
    .RF_WRITE      (RF_WRITE),
    .RF_ADDR       (RF_ADDR),
    .RF_DATA       (RF_DATA),
    .PENDING       (PENDING),
    .ERR           (ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rf_write;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        md_ready;
    logic        issue_ready;
    logic        rd1_busy;
    logic        rd2_busy;
    logic [31:0] pending;
    logic        err;
  } exp_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          due;
  } op_t;

  exp_t exp_q[$];
  exp_t mon_e;
  ent_t m_fifo[$];
  op_t  infl[$];
  bit   m_pend[32];
  int   m_out;
  bit   m_err;
  bit   last_hs;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    m_out = 0;
    m_err = 1'b0;
    m_fifo.delete();
    infl.delete();
  endtask

  task automatic idle_inputs();
    PIPE_WRITE = 1'b0; PIPE_ADDR = '0; PIPE_DATA = '0;
    MD_ISSUE = 1'b0; MD_ISSUE_ADDR = '0;
    MD_VALID = 1'b0; MD_ADDR = '0; MD_DATA = '0;
    RD1_ADDR = '0; RD2_ADDR = '0;
  endtask

  // Evaluate the reference model for the current inputs, queue the expectation, advance a clock.
  task automatic cycle();
    exp_t        e;
    bit          pipe_act, hs, keep, pop, byp;
    logic [31:0] pv;
    pipe_act      = PIPE_WRITE && (PIPE_ADDR != 0);
    e.md_ready    = m_fifo.size() < QD;
    hs            = MD_VALID && e.md_ready;
    keep          = hs && (MD_ADDR != 0);
    e.issue_ready = (m_out < MO) && !((MD_ISSUE_ADDR != 0) && m_pend[MD_ISSUE_ADDR]);
    for (int r = 0; r < 32; r++) pv[r] = m_pend[r];
    e.pending  = pv;
    e.err      = m_err;
    e.rd1_busy = (RD1_ADDR != 0) && m_pend[RD1_ADDR];
    e.rd2_busy = (RD2_ADDR != 0) && m_pend[RD2_ADDR];
    pop = 1'b0;
    byp = 1'b0;
    if (pipe_act) begin
      e.rf_write = 1'b1; e.rf_addr = PIPE_ADDR; e.rf_data = PIPE_DATA;
    end else if (m_fifo.size() > 0) begin
      e.rf_write = 1'b1; e.rf_addr = m_fifo[0].addr; e.rf_data = m_fifo[0].data;
      pop = 1'b1;
    end else if (keep) begin
      e.rf_write = 1'b1; e.rf_addr = MD_ADDR; e.rf_data = MD_DATA;
      byp = 1'b1;
    end else begin
      e.rf_write = 1'b0; e.rf_addr = PIPE_ADDR; e.rf_data = PIPE_DATA;
    end
    exp_q.push_back(e);
    if (pipe_act && m_pend[PIPE_ADDR]) m_err = 1'b1;
    if (keep && !m_pend[MD_ADDR]) m_err = 1'b1;
    if (MD_ISSUE && !e.issue_ready) m_err = 1'b1;
    if ((pop || byp) && m_pend[e.rf_addr]) begin
      m_pend[e.rf_addr] = 1'b0;
      m_out--;
    end
    if (pop) void'(m_fifo.pop_front());
    if (keep && !byp) m_fifo.push_back('{MD_ADDR, MD_DATA});
    if (MD_ISSUE && e.issue_ready && (MD_ISSUE_ADDR != 0)) begin
      m_pend[MD_ISSUE_ADDR] = 1'b1;
      m_out++;
    end
    last_hs = hs;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    idle_inputs();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic issue(input logic [4:0] a);
    idle_inputs();
    MD_ISSUE = 1'b1; MD_ISSUE_ADDR = a;
    cycle();
  endtask

  task automatic result(input logic [4:0] a, input logic [31:0] d);
    idle_inputs();
    MD_VALID = 1'b1; MD_ADDR = a; MD_DATA = d;
    cycle();
  endtask

  // Monitor: compare the DUT against the oldest queued expectation each cycle.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("rf_write",    32'(RF_WRITE),       32'(mon_e.rf_write));
      chk("rf_addr",     32'(RF_ADDR),        32'(mon_e.rf_addr));
      chk("rf_data",     RF_DATA,             mon_e.rf_data);
      chk("md_ready",    32'(MD_READY),       32'(mon_e.md_ready));
      chk("issue_ready", 32'(MD_ISSUE_READY), 32'(mon_e.issue_ready));
      chk("rd1_busy",    32'(RD1_BUSY),       32'(mon_e.rd1_busy));
      chk("rd2_busy",    32'(RD2_BUSY),       32'(mon_e.rd2_busy));
      chk("pending",     PENDING,             mon_e.pending);
      chk("err",         32'(ERR),            32'(mon_e.err));
    end
  end

  initial begin
    bit want;
    RESET = 1'b1;
    idle_inputs();
    model_reset();
    #3;
    chk("reset_rf_write", 32'(RF_WRITE), 32'd0);
    chk("reset_md_ready", 32'(MD_READY), 32'd0);
    chk("reset_issue_ready", 32'(MD_ISSUE_READY), 32'd0);
    chk("reset_pending", PENDING, 32'd0);
    chk("reset_err", 32'(ERR), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Bypass: x5 issued, result three cycles later, reader busy until the write edge.
    issue(5'd5);
    idle_inputs(); RD1_ADDR = 5'd5; cycle();
    idle_inputs(); RD1_ADDR = 5'd5; cycle();
    idle_inputs(); RD1_ADDR = 5'd5; MD_VALID = 1'b1; MD_ADDR = 5'd5; MD_DATA = 32'hFF; cycle();
    idle_inputs(); RD1_ADDR = 5'd5; cycle();

    // Queueing behind a held pipeline write, then FIFO-order drain; full FIFO refuses x11.
    issue(5'd3);
    issue(5'd4);
    issue(5'd11);
    idle_inputs(); PIPE_WRITE = 1'b1; PIPE_ADDR = 5'd7; PIPE_DATA = 32'h7070_0001;
    MD_VALID = 1'b1; MD_ADDR = 5'd3; MD_DATA = 32'h3333_0003; cycle();
    MD_ADDR = 5'd4; MD_DATA = 32'h4444_0004; cycle();
    MD_VALID = 1'b0; cycle();
    cycle();
    idle_inputs(); MD_VALID = 1'b1; MD_ADDR = 5'd11; MD_DATA = 32'hBBBB_000B; cycle();
    cycle();
    idle_inputs(); cycle();
    cycle();

    // Outstanding limit, WAW refusal, and same-cycle issue/retire netting.
    for (int i = 1; i <= 4; i++) issue(5'(i));
    idle_inputs(); MD_ISSUE_ADDR = 5'd9; cycle();
    idle_inputs(); MD_ISSUE_ADDR = 5'd2; cycle();
    idle_inputs(); MD_ISSUE_ADDR = 5'd9; MD_VALID = 1'b1; MD_ADDR = 5'd1; MD_DATA = 32'h1111_0001;
    cycle();
    issue(5'd9);
    result(5'd2, 32'h2222_0002);
    idle_inputs(); MD_VALID = 1'b1; MD_ADDR = 5'd3; MD_DATA = 32'h3333_0033;
    MD_ISSUE = 1'b1; MD_ISSUE_ADDR = 5'd6; cycle();
    idle_inputs(); MD_ISSUE_ADDR = 5'd10; cycle();
    issue(5'd10);
    idle_inputs(); MD_ISSUE_ADDR = 5'd11; cycle();

    // Reset mid-cycle with two queued results and x5/x8 pending.
    do_reset();
    issue(5'd5);
    issue(5'd8);
    idle_inputs(); PIPE_WRITE = 1'b1; PIPE_ADDR = 5'd7; PIPE_DATA = 32'h0000_0777;
    MD_VALID = 1'b1; MD_ADDR = 5'd5; MD_DATA = 32'h5555_0005; cycle();
    MD_ADDR = 5'd8; MD_DATA = 32'h8888_0008; cycle();
    MD_VALID = 1'b0; RD1_ADDR = 5'd5; RD2_ADDR = 5'd8;
    chk("pre_reset_pending", PENDING, 32'h0000_0120);
    #1;
    RESET = 1'b1;
    #1;
    chk("midreset_rf_write", 32'(RF_WRITE), 32'd0);
    chk("midreset_md_ready", 32'(MD_READY), 32'd0);
    chk("midreset_issue_ready", 32'(MD_ISSUE_READY), 32'd0);
    chk("midreset_rd1_busy", 32'(RD1_BUSY), 32'd0);
    chk("midreset_rd2_busy", 32'(RD2_BUSY), 32'd0);
    chk("midreset_pending", PENDING, 32'd0);
    chk("midreset_err", 32'(ERR), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
    idle_inputs(); MD_ISSUE_ADDR = 5'd5; cycle();
    cycle();

    // Randomized traffic with a behavioural mul/div unit returning results in order.
    for (int n = 0; n < 1500; n++) begin
      idle_inputs();
      if (infl.size() > 0 && infl[0].due <= cyc) begin
        MD_VALID = 1'b1; MD_ADDR = infl[0].addr; MD_DATA = infl[0].data;
      end
      PIPE_ADDR  = 5'($urandom_range(0, 31));
      PIPE_DATA  = $urandom();
      PIPE_WRITE = ($urandom_range(0, 1) == 0) && !m_pend[PIPE_ADDR];
      MD_ISSUE_ADDR = 5'($urandom_range(0, 15));
      want     = ($urandom_range(0, 2) == 0);
      MD_ISSUE = want && (m_out < MO) && !((MD_ISSUE_ADDR != 0) && m_pend[MD_ISSUE_ADDR]);
      RD1_ADDR = 5'($urandom_range(0, 15));
      RD2_ADDR = 5'($urandom_range(0, 15));
      cycle();
      if (last_hs) void'(infl.pop_front());
      if (MD_ISSUE) infl.push_back('{MD_ISSUE_ADDR, $urandom(), cyc + int'($urandom_range(1, 4))});
      cyc++;
    end

    // Pipeline WAW raises a sticky error; x0 results and issues change nothing.
    do_reset();
    issue(5'd8);
    idle_inputs(); PIPE_WRITE = 1'b1; PIPE_ADDR = 5'd8; PIPE_DATA = 32'hDEAD_0008; cycle();
    result(5'd8, 32'h8000_0008);
    result(5'd0, 32'h0000_FFFF);
    issue(5'd0);
    idle_inputs(); cycle();
    cycle();
    chk("err_sticky", 32'(ERR), 32'd1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
